// File: rtl/fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue -- instruction prefetch buffer between I-memory and decode.
//
// A request/response fetcher keeps up to MAX_OUT requests in flight. Returned
// words are tagged with their PC and queued in a DEPTH-entry FIFO that feeds
// the decode register. A redirect empties the FIFO, restarts fetch at the new
// PC and marks every in-flight request so that its response is dropped.
//
// Ports
//   clk, rst               clock (rising edge), async active-low reset
//   im_req_valid/_pc/_ready   fetch request handshake to memory
//   im_resp_valid/_inst       in-order response from memory
//   redirect_valid/_pc        taken jump/branch, flush and refetch
//   d_ready                   decode accepts head entry
//   d_valid/_inst/_pc         head entry (NOP / 0 when empty)
// ----------------------------------------------------------------------------
module fetch_queue_store #(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [PW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [PW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  // Data-only storage: validity is tracked by the pointers/count in the
  // parent, so no reset is needed here.
  logic [DEPTH-1:0][W-1:0] mem_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter int              MAX_OUT  = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  // memory request
  output logic            im_req_valid,
  output logic [XLEN-1:0] im_req_pc,
  input  logic            im_req_ready,
  // memory response
  input  logic            im_resp_valid,
  input  logic [31:0]     im_resp_inst,
  // redirect
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  // decode side
  input  logic            d_ready,
  output logic            d_valid,
  output logic [31:0]     d_inst,
  output logic [XLEN-1:0] d_pc
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = ((CW > OW) ? CW : OW) + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
  } entry_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] exp_pc_q,   exp_pc_d;
  logic [CW-1:0]   count_q,    count_d;
  logic [OW-1:0]   out_q,      out_d;
  logic [OW-1:0]   drop_q,     drop_d;
  logic [PW-1:0]   rd_ptr_q,   rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q,   wr_ptr_d;

  logic            resp_ok, accept, push, pop;
  logic [SW-1:0]   credit;
  entry_t          wr_entry, rd_entry;

  // Slots already promised: queued entries plus in-flight responses that will
  // be kept. Issuing only while this is below DEPTH guarantees every kept
  // response finds a free FIFO slot, so no backpressure on responses exists.
  assign credit = SW'(count_q) + SW'(out_q) - SW'(drop_q);

  // rst gates the request so it is low for the whole reset assertion, not just
  // after the registers have cleared.
  assign im_req_valid = rst && !redirect_valid
                        && (out_q < OW'(MAX_OUT))
                        && (credit < SW'(DEPTH));
  assign im_req_pc    = fetch_pc_q;

  assign d_valid = (count_q != '0);
  assign d_inst  = d_valid ? rd_entry.inst : NOP;
  assign d_pc    = d_valid ? rd_entry.pc   : '0;

  assign wr_entry = '{inst: im_resp_inst, pc: exp_pc_q};

  always_comb begin
    // A response with nothing outstanding is a protocol violation; it must
    // not touch any counter.
    resp_ok  = im_resp_valid && (out_q != '0);
    accept   = im_req_valid && im_req_ready;
    push     = resp_ok && (drop_q == '0) && !redirect_valid;
    pop      = d_valid && d_ready && !redirect_valid;

    fetch_pc_d = fetch_pc_q;
    exp_pc_d   = exp_pc_q;
    count_d    = count_q;
    drop_d     = drop_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    out_d      = out_q + OW'(accept) - OW'(resp_ok);

    if (redirect_valid) begin
      // Everything still in flight after this cycle is stale, including the
      // request whose response arrives in this very cycle.
      fetch_pc_d = redirect_pc;
      exp_pc_d   = redirect_pc;
      count_d    = '0;
      rd_ptr_d   = wr_ptr_q;
      drop_d     = out_q - OW'(resp_ok);
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (resp_ok && (drop_q != '0)) drop_d = drop_q - OW'(1);
      if (push) begin
        exp_pc_d = exp_pc_q + XLEN'(4);
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      exp_pc_q   <= RESET_PC;
      count_q    <= '0;
      out_q      <= '0;
      drop_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      exp_pc_q   <= exp_pc_d;
      count_q    <= count_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  fetch_queue_store #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_store (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry)
  );

  // The credit rule makes a kept response into a full queue impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
                                  push |-> (count_q < CW'(DEPTH)));
endmodule
